// File: rtl/multiplexer_arb.sv
// multiplexer_arb: CHANNELS-input, WIDTH-bit stream multiplexer with valid/ready
// handshakes on each input and on the single registered output.
//
// A combinational arbiter picks one requesting channel per cycle. The pick is
// round-robin or fixed priority (lowest index wins), chosen by arb_mode.
//
// Ports:
//   clock     - system clock, rising edge
//   reset     - synchronous, active-high reset
//   in_data   - flattened input words; channel i at [i*WIDTH +: WIDTH]
//   in_valid  - per-channel request
//   in_ready  - per-channel accept (combinational, at most one bit set)
//   arb_mode  - 0 = round-robin, 1 = fixed priority
//   out_data  - registered selected word
//   out_sel   - registered index of the channel that supplied out_data
//   out_valid - registered; out_data/out_sel hold a word
//   out_ready - downstream accept
module multiplexer_arb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_BITS = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      arb_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Channel count in the widened index width used for the modulo scan.
  localparam logic [SEL_BITS:0] ChanCnt  = (SEL_BITS+1)'(CHANNELS);
  localparam logic [SEL_BITS-1:0] LastCh = SEL_BITS'(CHANNELS - 1);

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic                load;
  logic                grant_found;
  logic [SEL_BITS-1:0] grant_idx;
  logic [SEL_BITS:0]   rr_cand;
  logic [SEL_BITS-1:0] rr_idx;
  logic                transfer;

  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic                valid_q, valid_d;
  logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // The output register can take a word when empty or being drained this cycle.
  assign load = !valid_q | out_ready;

  // Both scans run from the far end toward the preferred end so the last hit,
  // i.e. the preferred requester, is the one that sticks.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_cand     = '0;
    rr_idx      = '0;
    if (arb_mode) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = SEL_BITS'(i);
        end
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        // rr_ptr + k modulo CHANNELS; one conditional subtract is enough since
        // both operands are below CHANNELS.
        rr_cand = {1'b0, rr_ptr_q} + (SEL_BITS+1)'(k);
        if (rr_cand >= ChanCnt) begin
          rr_cand = rr_cand - ChanCnt;
        end
        rr_idx = rr_cand[SEL_BITS-1:0];
        if (in_valid[rr_idx]) begin
          grant_found = 1'b1;
          grant_idx   = rr_idx;
        end
      end
    end
  end

  assign transfer = load & grant_found & !reset;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = transfer & (grant_idx == SEL_BITS'(i));
    end
  end

  always_comb begin
    data_d   = data_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      // A new word overwrites any word draining this cycle: no bubble.
      data_d   = chan_data[grant_idx];
      sel_d    = grant_idx;
      valid_d  = 1'b1;
      rr_ptr_d = (grant_idx == LastCh) ? '0 : grant_idx + SEL_BITS'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q   <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule
